// File: rtl/aer_spike_encoder.sv
// AER transmitter: latches single-cycle neuron spikes, arbitrates round-robin,
// and emits {address, timestamp} events on a valid/ready link.
`timescale 1ns/1ps
module aer_spike_encoder #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int TS_WIDTH    = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   aer_valid,
  input  logic                   aer_ready,
  output logic [ADDR_WIDTH-1:0]  aer_addr,
  output logic [TS_WIDTH-1:0]    aer_ts,
  output logic [DROP_WIDTH-1:0]  drop_count,
  input  logic                   drop_clr,
  output logic                   idle
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = ((DROP_WIDTH > CNT_W) ? DROP_WIDTH : CNT_W) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [NUM_NEURONS-1:0] pending;
  logic [TS_WIDTH-1:0]    ts;
  logic [ADDR_WIDTH-1:0]  rr_ptr;

  logic                   load;
  logic                   hi_found, lo_found;
  logic [ADDR_WIDTH-1:0]  hi_idx, lo_idx, grant_idx;
  logic [NUM_NEURONS-1:0] grant_vec;
  logic [NUM_NEURONS-1:0] merge_vec;
  logic [CNT_W-1:0]       merge_cnt;
  logic [SUM_W-1:0]       drop_sum;
  logic [DROP_WIDTH-1:0]  drop_next;

  // Link handshake: an event transfers on any edge where aer_valid && aer_ready.
  // Once raised, aer_valid/aer_addr/aer_ts are frozen until that transfer, and a
  // new event may be loaded on the very edge the current one transfers.
  assign load = (!aer_valid || aer_ready) && (pending != '0);

  // Round-robin: lowest pending index at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (pending[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ADDR_WIDTH'(i);
        end
        if (!hi_found && (ADDR_WIDTH'(i) >= rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = ADDR_WIDTH'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_vec = '0;
    merge_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      grant_vec[i] = load && (ADDR_WIDTH'(i) == grant_idx);
    end
    // A spike on a granted neuron refills its pending bit instead of merging.
    merge_vec = spike_in & pending & ~grant_vec;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      merge_cnt = merge_cnt + CNT_W'(merge_vec[i]);
    end
    drop_sum  = SUM_W'(drop_count) + SUM_W'(merge_cnt);
    drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      aer_valid  <= 1'b0;
      aer_addr   <= '0;
      aer_ts     <= '0;
      drop_count <= '0;
    end else begin
      ts      <= ts + TS_WIDTH'(1);
      pending <= (pending & ~grant_vec) | spike_in;
      if (drop_clr) begin
        drop_count <= '0;
      end else begin
        drop_count <= drop_next;
      end
      if (load) begin
        aer_valid <= 1'b1;
        aer_addr  <= grant_idx;
        aer_ts    <= ts;
        rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ADDR_WIDTH'(1);
      end else if (aer_ready) begin
        aer_valid <= 1'b0;
      end
    end
  end

  assign idle = (pending == '0) && !aer_valid;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Scoreboard bench for aer_spike_encoder: a set-based reference model predicts
// every event and the drop counter; a negedge monitor checks the link.
`timescale 1ns/1ps
module tb_aer_spike_encoder;

  localparam int NUM = 16;
  localparam int AW  = 4;
  localparam int TW  = 8;
  localparam int DW  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM-1:0] spike_in;
  logic           aer_valid;
  logic           aer_ready;
  logic [AW-1:0]  aer_addr;
  logic [TW-1:0]  aer_ts;
  logic [DW-1:0]  drop_count;
  logic           drop_clr;
  logic           idle;

  aer_spike_encoder #(
    .NUM_NEURONS(NUM), .ADDR_WIDTH(AW), .TS_WIDTH(TW), .DROP_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in),
    .aer_valid(aer_valid), .aer_ready(aer_ready),
    .aer_addr(aer_addr), .aer_ts(aer_ts),
    .drop_count(drop_count), .drop_clr(drop_clr), .idle(idle)
  );

  // ---------------- scoreboard state ----------------
  logic [AW+TW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending spikes kept as a set of flags; events are the spec's rules applied per edge.
  bit m_pend[NUM];
  bit m_valid;
  int m_rr, m_ts, m_drop;

  function automatic bit m_idle();
    for (int i = 0; i < NUM; i++) if (m_pend[i]) return 1'b0;
    return !m_valid;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_rr    = 0;
        m_ts    = 0;
        m_drop  = 0;
        exp_q.delete();
      end else begin
        int g;
        int merges;
        g = -1;
        if (!m_valid || aer_ready) begin
          for (int k = 0; k < NUM; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % NUM]) g = (m_rr + k) % NUM;
          end
        end
        if (g >= 0) begin
          exp_q.push_back({AW'(g), TW'(m_ts)});
          m_valid = 1'b1;
          m_rr    = (g + 1) % NUM;
        end else if (m_valid && aer_ready) begin
          m_valid = 1'b0;
        end
        merges = 0;
        for (int i = 0; i < NUM; i++) begin
          if (spike_in[i] && m_pend[i] && i != g) merges++;
        end
        if (drop_clr) m_drop = 0;
        else m_drop = (m_drop + merges > 255) ? 255 : m_drop + merges;
        for (int i = 0; i < NUM; i++) begin
          m_pend[i] = (m_pend[i] && i != g) || spike_in[i];
        end
        m_ts = (m_ts + 1) % 256;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("aer_valid", 32'(aer_valid), 32'(m_valid));
      check("idle", 32'(idle), 32'(m_idle()));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      if (aer_valid && aer_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(aer_addr), 32'hFFFF_FFFF);
        end else begin
          logic [AW+TW-1:0] e;
          e = exp_q.pop_front();
          check("aer_addr", 32'(aer_addr), 32'(e[AW+TW-1:TW]));
          check("aer_ts", 32'(aer_ts), 32'(e[TW-1:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [NUM-1:0] s, input logic r, input logic c);
    spike_in  = s;
    aer_ready = r;
    drop_clr  = c;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(aer_valid), 32'd0);
    check({tag, "_addr"}, 32'(aer_addr), 32'd0);
    check({tag, "_ts"}, 32'(aer_ts), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    spike_in = '0; aer_ready = 1'b0; drop_clr = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // single spike on neuron 5
    drive(16'h0020, 1'b1, 1'b0);
    repeat (4) drive('0, 1'b1, 1'b0);

    // burst 2, 7, 11 then round-robin 12 before 3
    drive(16'h0884, 1'b1, 1'b0);
    repeat (5) drive('0, 1'b1, 1'b0);
    drive(16'h1008, 1'b1, 1'b0);
    repeat (4) drive('0, 1'b1, 1'b0);

    // backpressure with event 4 held, neuron 9 merged once
    drive(16'h0010, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    check("bp_addr_held", 32'(aer_addr), 32'd4);
    check("bp_drop", 32'(drop_count), 32'd1);
    repeat (3) drive('0, 1'b1, 1'b0);
    drive('0, 1'b1, 1'b1);
    check("drop_clr", 32'(drop_count), 32'd0);

    // grant and new spike on neuron 1 at the same edge
    drive(16'h0002, 1'b1, 1'b0);
    drive(16'h0002, 1'b1, 1'b0);
    repeat (4) drive('0, 1'b1, 1'b0);
    check("collision_drop", 32'(drop_count), 32'd0);

    // drop counter saturation, then clear racing merges
    repeat (30) drive('1, 1'b0, 1'b0);
    check("drop_saturate", 32'(drop_count), 32'd255);
    drive('1, 1'b0, 1'b1);
    check("clr_beats_merge", 32'(drop_count), 32'd0);
    repeat (40) drive('0, 1'b1, 1'b0);

    // randomized traffic
    repeat (400) begin
      drive(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 24) == 0));
    end
    repeat (40) drive('0, 1'b1, 1'b0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);

    // asynchronous reset while an event is stalled on the link
    drive(16'h0f0f, 1'b0, 1'b0);
    drive(16'h00ff, 1'b0, 1'b0);
    drive(16'h0f00, 1'b0, 1'b0);
    check("pre_reset_valid", 32'(aer_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    drive(16'h8000, 1'b1, 1'b0);
    repeat (5) drive('0, 1'b1, 1'b0);
    check("post_reset_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
